// File: rtl/fp_norm_arbiter_if.sv
// Bus bundle for fp_norm_arbiter: the per-leg request/data/ack side plus the
// valid/ready result side. The arbiter takes the slave view; the requesters
// and the result consumer take the master view.
interface fp_norm_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int MW    = 24,
  parameter int EW    = 8,
  parameter int CW    = 5
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    in_sign;
  logic [N_REQ*EW-1:0] in_exp;
  logic [N_REQ*MW-1:0] in_man;
  logic [N_REQ-1:0]    ack;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [EW-1:0]       out_exp;
  logic [MW-1:0]       out_man;
  logic [CW-1:0]       out_shift;
  logic                out_zero;
  logic [1:0]          out_src;

  modport slave (
    input  req, in_sign, in_exp, in_man, out_ready,
    output ack, out_valid, out_sign, out_exp, out_man, out_shift, out_zero, out_src
  );

  modport master (
    output req, in_sign, in_exp, in_man, out_ready,
    input  ack, out_valid, out_sign, out_exp, out_man, out_shift, out_zero, out_src
  );
endinterface

// File: rtl/fp_norm_arbiter.sv
// Shared leading-zero-count / normalize datapath for the legs of a radix-3
// butterfly. A round-robin arbiter picks one leg, its operand is latched,
// the shift is counted, then the mantissa/exponent are normalized and held
// on a valid/ready port tagged with the source index.
module fp_norm_arbiter #(
  parameter int N_REQ = 3,
  parameter int MW    = 24,
  parameter int EW    = 8,
  parameter int CW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic            busy,
  fp_norm_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    ptr;
  logic [1:0]    src_q;
  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic [MW-1:0] man_q;
  logic [CW-1:0] shift_q;

  logic          gnt_found;
  logic [1:0]    gnt_idx;
  logic [1:0]    scan;
  logic [CW-1:0] lz;
  logic [MW-1:0] lz_t;
  logic          lz_done;

  assign busy = (state != IDLE);

  // Round-robin pick: first asserted request walking cyclically from ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_found && bus.req[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
      scan = (scan == 2'(N_REQ - 1)) ? '0 : scan + 2'd1;
    end
  end

  // Leading-zero count of the latched mantissa; zero mantissa yields 0.
  always_comb begin
    lz      = '0;
    lz_t    = man_q;
    lz_done = 1'b0;
    for (int unsigned b = 0; b < MW; b++) begin
      if (!lz_done) begin
        if (lz_t[MW-1]) begin
          lz_done = 1'b1;
        end else begin
          lz_t = lz_t << 1;
          lz   = lz + 1'b1;
        end
      end
    end
    if (man_q == '0) lz = '0;
  end

  // Arbitration / capture / normalize / output sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      src_q         <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      man_q         <= '0;
      shift_q       <= '0;
      bus.ack       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.out_exp   <= '0;
      bus.out_man   <= '0;
      bus.out_shift <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_src   <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            src_q   <= gnt_idx;
            sign_q  <= bus.in_sign[gnt_idx];
            exp_q   <= bus.in_exp[gnt_idx*EW +: EW];
            man_q   <= bus.in_man[gnt_idx*MW +: MW];
            bus.ack <= N_REQ'(1) << gnt_idx;
            state   <= CAPT;
          end
        end
        CAPT: begin
          shift_q <= lz;
          state   <= NORM;
        end
        NORM: begin
          bus.out_sign  <= sign_q;
          bus.out_shift <= shift_q;
          bus.out_src   <= src_q;
          if (man_q == '0 || 32'(exp_q) <= 32'(shift_q)) begin
            bus.out_exp  <= '0;
            bus.out_man  <= '0;
            bus.out_zero <= 1'b1;
          end else begin
            bus.out_exp  <= exp_q - EW'(shift_q);
            bus.out_man  <= man_q << shift_q;
            bus.out_zero <= 1'b0;
          end
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        default: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            ptr           <= (src_q == 2'(N_REQ - 1)) ? '0 : src_q + 2'd1;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Bench for fp_norm_arbiter: directed cases followed by randomized traffic,
// checked against a behavioural normalize/round-robin model.
module tb_fp_norm_arbiter;
  localparam int N  = 3;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int n_assert = 0;
  int n_fail   = 0;

  int sgn_a [N];
  int exp_a [N];
  int man_a [N];
  int ptr_m = 0;

  fp_norm_arbiter_if #(.N_REQ(N), .MW(MW), .EW(EW), .CW(CW)) bus ();

  fp_norm_arbiter #(.N_REQ(N), .MW(MW), .EW(EW), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_data(input int i, input int s, input int e, input int m);
    sgn_a[i] = s;
    exp_a[i] = e;
    man_a[i] = m;
    bus.in_sign[i]           = s[0];
    bus.in_exp[i*EW +: EW]   = e[EW-1:0];
    bus.in_man[i*MW +: MW]   = m[MW-1:0];
  endtask

  // Normalize by repeated doubling until the hidden-one position is reached.
  task automatic ref_norm(input int e, input int m, output int s, output int eo,
                          output int mo, output int z);
    int t;
    s = 0;
    t = m;
    if (m == 0) begin
      eo = 0; mo = 0; z = 1;
    end else begin
      while (t < (1 << (MW - 1))) begin
        t = t * 2;
        s = s + 1;
      end
      if (e > s) begin
        eo = e - s; mo = t; z = 0;
      end else begin
        eo = 0; mo = 0; z = 1;
      end
    end
  endtask

  function automatic int pick(input int rq, input int p);
    for (int k = 0; k < N; k++) begin
      if ((rq >> ((p + k) % N)) & 1) return (p + k) % N;
    end
    return -1;
  endfunction

  // One full transaction starting at a negedge with the DUT in IDLE.
  task automatic txn(input int rq, input int hold);
    int g, s, eo, mo, z;
    logic [MW-1:0] man_seen;
    g = pick(rq, ptr_m);
    ref_norm(exp_a[g], man_a[g], s, eo, mo, z);
    bus.req       = rq[N-1:0];
    bus.out_ready = (hold == 0);
    @(negedge clk);
    chk("ack_grant", 64'(bus.ack), 64'(1 << g));
    chk("busy_capt", 64'(busy), 64'd1);
    chk("valid_capt", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("ack_pulse", 64'(bus.ack), 64'd0);
    chk("valid_norm", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("valid_out", 64'(bus.out_valid), 64'd1);
    chk("out_src", 64'(bus.out_src), 64'(g));
    chk("out_sign", 64'(bus.out_sign), 64'(sgn_a[g] & 1));
    chk("out_shift", 64'(bus.out_shift), 64'(s));
    chk("out_exp", 64'(bus.out_exp), 64'(eo));
    chk("out_man", 64'(bus.out_man), 64'(mo));
    chk("out_zero", 64'(bus.out_zero), 64'(z));
    man_seen = bus.out_man;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_man", 64'(bus.out_man), 64'(man_seen));
      chk("bp_src", 64'(bus.out_src), 64'(g));
      chk("bp_ack", 64'(bus.ack), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", 64'(bus.out_valid), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    ptr_m = (g + 1) % N;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 64'(bus.ack), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_fields"}, {bus.out_sign, bus.out_exp, bus.out_man, bus.out_shift,
                           bus.out_zero, bus.out_src}, 64'd0);
  endtask

  initial begin
    int rq, m;
    rst           = 1'b1;
    bus.req       = '0;
    bus.in_sign   = '0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // All legs requesting: strict rotation 0,1,2,0.
    set_data(0, 0, 50, 'h400000);
    set_data(1, 1, 60, 'h00F000);
    set_data(2, 0, 70, 'h000003);
    for (int i = 0; i < 4; i++) txn(7, 0);

    // Worked example with literal expectations.
    set_data(0, 1, 100, 'h012345);
    txn(1, 0);
    chk("tp_shift", 64'(bus.out_shift), 64'd7);
    chk("tp_man", 64'(bus.out_man), 64'h91A280);
    chk("tp_exp", 64'(bus.out_exp), 64'd93);

    // Boundaries and underflow.
    set_data(0, 0, 5, 'h800000);   txn(1, 0);
    set_data(0, 1, 30, 'h000001);  txn(1, 0);
    chk("b1_man", 64'(bus.out_man), 64'h800000);
    chk("b1_exp", 64'(bus.out_exp), 64'd7);
    set_data(0, 0, 77, 0);         txn(1, 0);
    set_data(0, 1, 15, 'h000100);  txn(1, 0);
    chk("uf_zero", 64'(bus.out_zero), 64'd1);
    chk("uf_shift", 64'(bus.out_shift), 64'd15);

    // Backpressure with legs 0 and 1 both requesting.
    txn(4, 0);
    txn(3, 10);
    txn(3, 0);

    // Asynchronous reset while the operation is in NORM.
    bus.req = 3'b100;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("arst_hold");
    rst = 1'b0;
    ptr_m = 0;
    txn(4, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        m = int'($urandom & 32'hFFFFFF) >> $urandom_range(0, 24);
        set_data(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), m);
      end
      rq = int'($urandom_range(1, 7));
      txn(rq, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_norm_arbiter.md
Name: fp_norm_arbiter

Overview:
- Shares one leading-zero-count/normalize datapath between the N_REQ unnormalized results of a radix-3 butterfly (default 3 legs).
- A round-robin arbiter grants one requester at a time. The FSM latches its sign/exponent/mantissa, computes the leading-zero shift, left-shifts the mantissa and adjusts the exponent.
- The normalized word is presented on a valid/ready output port, tagged with the source index.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- MW, 24, mantissa width; bit MW-1 is the hidden-one position.
- EW, 8, exponent width (unsigned, biased).
- CW, 5, shift-count width; must satisfy 2^CW >= MW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request; held with data until ack.
- in_sign  in  N_REQ  sign of requester i at bit i.
- in_exp  in  N_REQ*EW  exponent of requester i at [i*EW +: EW].
- in_man  in  N_REQ*MW  unnormalized mantissa of requester i at [i*MW +: MW].
- ack  out  N_REQ  one-hot, one-cycle pulse: data of requester i captured.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  normalized result available.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  sign of result.
- out_exp  out  EW  normalized exponent.
- out_man  out  MW  normalized mantissa.
- out_shift  out  CW  shift count applied.
- out_zero  out  1  result is zero (zero mantissa or underflow flush).
- out_src  out  2  index of the granted requester.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - ack, busy, out_valid, out_sign, out_exp, out_man, out_shift, out_zero and out_src all go to 0.
  - Any in-flight operation is discarded with no ack and no output.
- FSM states: IDLE -> CAPT -> NORM -> OUT -> IDLE.
  - IDLE: if req != 0, pick the first set bit scanning cyclically from the pointer. Latch that requester's sign/exp/man and its index. Go to CAPT. If req == 0, stay in IDLE.
  - CAPT: ack[src]=1 for exactly this cycle. Compute shift count S into a register. Go to NORM.
  - NORM: compute result fields into the output registers. Go to OUT.
  - OUT: out_valid=1. All out_* fields stay stable until out_valid&&out_ready. On that handshake, set pointer = (src+1) mod N_REQ and go to IDLE; out_valid is 0 from the next cycle.
- Timing:
  - Latency: req sampled in IDLE at edge k gives ack high in cycle k+1 and out_valid in cycle k+3.
  - Minimum issue interval is 4 cycles.
- req is not sampled outside IDLE. A requester must drop req (or present new data) on the edge where ack=1, otherwise it is re-eligible at the next IDLE.
- Shift count S, for mantissa M:
  - M[MW-1]=1: S=0.
  - M=0: S=0, and the zero path applies.
  - Otherwise: S = number of leading zeros of M (1..MW-1). For MW=24, M=24'h000001 gives S=23.
- Result for M != 0:
  - If exp > S: out_exp = exp - S, out_man = M << S (MSB set), out_zero=0.
  - If exp <= S (underflow): out_exp=0, out_man=0, out_zero=1.
- Result for M = 0: out_exp=0, out_man=0, out_zero=1.
- In all cases: out_sign = latched sign, out_shift = S, out_src = latched index.
- Simultaneous requests: strict round-robin from the pointer. Every active requester is served within N_REQ grants.
- Output backpressure: if out_ready is held low, the FSM remains in OUT indefinitely. No new capture occurs and no ack is issued.

Test Plan:
- Single request: req=001, man0=24'h012345, exp0=8'd100, sign0=1 -> ack=001 one cycle after req sampled; out_valid 3 cycles after; out_shift=7, out_man=24'h91A280, out_exp=93, out_sign=1, out_src=0.
- All requesters held (req=111), out_ready=1 -> grant order 0,1,2,0; one ack per 4 cycles; out_src sequence 0,1,2,0.
- Boundaries: man=24'h800000, exp=5 -> S=0, exp 5, man unchanged. man=24'h000001, exp=30 -> S=23, exp 7, man 24'h800000. man=0 -> out_zero=1, exp 0, man 0.
- Underflow: man=24'h000100, exp=15 (S=15, exp<=S) -> out_zero=1, out_exp=0, out_man=0, out_shift=15.
- Backpressure: out_ready=0 for 10 cycles with req=011 -> out_valid and fields stable, busy=1, no second ack. Raise out_ready -> handshake, then requester 1 is granted next.
- Async reset asserted in NORM between clock edges -> all outputs 0 immediately, no out_valid. After release with req=100 -> requester 2 is granted (pointer=0 scan), ack=100.
